// File: rtl/vector_pkg.sv
// Shared types and sizing for the vector micro-op sequencer.
// The optional masked-beat skipping is selected with VSEQ_MASK_SKIP_EN.
package vector_pkg;

  localparam int NUM_LANES = 4;
  localparam int VLMAX     = 128;
  localparam int UOP_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } vseq_state_t;

endpackage

// File: rtl/mask_unit.sv
// Per-beat lane enable: qualifies the active lanes with the matching v0 nibble.
module mask_unit
  import vector_pkg::*;
(
  input  logic [VLMAX-1:0] i_v0,
  input  logic             i_mask_en,
  input  logic [UOP_W-1:0] i_ctr,
  input  logic [3:0]       i_lane_active,
  output logic [3:0]       o_lane_en
);

  logic [3:0] w_v0_bits;

  // Beat n covers elements 4n..4n+3, i.e. v0 nibble n.
  assign w_v0_bits = i_v0[{i_ctr, 2'b00} +: 4];
  assign o_lane_en = i_mask_en ? (i_lane_active & w_v0_bits) : i_lane_active;

endmodule

// File: rtl/vector_uop_sequencer.sv
// Splits one vector instruction into 4-lane micro-op beats with mask-qualified lane enables.
// Define VSEQ_MASK_SKIP_EN to skip fully-masked beats instead of presenting them.
module vector_uop_sequencer
  import vector_pkg::*;
(
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [7:0]       issue_vl,
  input  logic             issue_mask_en,
  input  logic [VLMAX-1:0] issue_v0,
  output logic             uop_valid,
  input  logic             uop_ready,
  output logic [UOP_W-1:0] uop_num,
  output logic [3:0]       lane_active,
  output logic [3:0]       lane_en,
  output logic             uop_last,
  output logic             busy,
  output logic             done,
  output vseq_state_t      dbg_state
);

  // Handshakes: issue transfers on issue_valid & issue_ready; a beat transfers on
  // uop_valid & uop_ready, and every beat output holds steady until that transfer.

  vseq_state_t      r_state;
  logic [UOP_W-1:0] r_ctr;
  logic [UOP_W-1:0] r_last;
  logic [7:0]       r_vl;
  logic             r_mask_en;
  logic [VLMAX-1:0] r_v0;

  logic [7:0]       w_vl_c;
  logic [7:0]       w_vl_m1;
  logic             w_run;
  logic             w_skip;
  logic             w_present;
  logic             w_adv;
  logic [3:0]       w_lane_active;
  logic [3:0]       w_lane_en;

  assign w_vl_c  = (issue_vl > 8'd128) ? 8'd128 : issue_vl;
  assign w_vl_m1 = w_vl_c - 8'd1;
  assign w_run   = (r_state == RUN);

  always_comb begin
    w_lane_active = 4'b0000;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_lane_active[i] = w_run && (({1'b0, r_ctr, 2'b00} + 8'(i)) < r_vl);
    end
  end

  mask_unit u_mask_unit (
    .i_v0          (r_v0),
    .i_mask_en     (r_mask_en),
    .i_ctr         (r_ctr),
    .i_lane_active (w_lane_active),
    .o_lane_en     (w_lane_en)
  );

`ifdef VSEQ_MASK_SKIP_EN
  assign w_skip = w_run && r_mask_en && (w_lane_en == 4'b0000);
`else
  assign w_skip = 1'b0;
`endif

  assign w_present = w_run && !w_skip;
  // A skipped beat retires without waiting for the lanes.
  assign w_adv     = (w_present && uop_ready) || w_skip;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_ctr     <= '0;
      r_last    <= '0;
      r_vl      <= '0;
      r_mask_en <= 1'b0;
      r_v0      <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_ctr   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (issue_valid) begin
            r_vl      <= w_vl_c;
            r_mask_en <= issue_mask_en;
            r_v0      <= issue_v0;
            r_ctr     <= '0;
            r_last    <= w_vl_m1[6:2];
            r_state   <= (w_vl_c == 8'd0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (w_adv) begin
            if (r_ctr == r_last) r_state <= DONE;
            else                 r_ctr   <= r_ctr + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ctr   <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign issue_ready = (r_state == IDLE);
  assign uop_valid   = w_present;
  assign uop_num     = r_ctr;
  assign uop_last    = w_run && (r_ctr == r_last);
  assign lane_active = w_lane_active;
  assign lane_en     = w_lane_en;
  assign busy        = (r_state != IDLE);
  assign done        = (r_state == DONE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_vector_uop_sequencer.sv
// Directed bench for vector_uop_sequencer: table of short instructions plus
// hand-written long, zero-length, flush and mid-run reset sequences.
module tb_vector_uop_sequencer;
  import vector_pkg::*;

  logic         CLK;
  logic         nRST;
  logic         flush;
  logic         issue_valid;
  logic         issue_ready;
  logic [7:0]   issue_vl;
  logic         issue_mask_en;
  logic [127:0] issue_v0;
  logic         uop_valid;
  logic         uop_ready;
  logic [4:0]   uop_num;
  logic [3:0]   lane_active;
  logic [3:0]   lane_en;
  logic         uop_last;
  logic         busy;
  logic         done;
  vseq_state_t  dbg_state;

  int checks;
  int failures;

  vector_uop_sequencer dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_vl      (issue_vl),
    .issue_mask_en (issue_mask_en),
    .issue_v0      (issue_v0),
    .uop_valid     (uop_valid),
    .uop_ready     (uop_ready),
    .uop_num       (uop_num),
    .lane_active   (lane_active),
    .lane_en       (lane_en),
    .uop_last      (uop_last),
    .busy          (busy),
    .done          (done),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  vl;
    logic        mask_en;
    logic [15:0] v0;
    logic [7:0]  present;
    logic [15:0] exp_la;
    logic [15:0] exp_en;
    logic [4:0]  last_num;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [7:0] vl, input logic m, input logic [127:0] v0);
    @(negedge CLK);
    check("issue_ready_idle", {31'b0, issue_ready}, 32'd1);
    issue_valid   = 1'b1;
    issue_vl      = vl;
    issue_mask_en = m;
    issue_v0      = v0;
    @(negedge CLK);
    issue_valid = 1'b0;
  endtask

  task automatic run_case(input vec_t v);
    int ptr;
    int seen;
    int cyc;
    bit got_done;
    ptr = 0; seen = 0; cyc = 0; got_done = 0;
    uop_ready = 1'b1;
    issue(v.vl, v.mask_en, {112'b0, v.v0});
    check("busy_after_issue", {31'b0, busy}, 32'd1);
    while (!got_done && cyc < 80) begin
      if (done) got_done = 1;
      else begin
        if (uop_valid) begin
          while (ptr < 8 && !v.present[ptr]) ptr++;
          check("beat_num", {27'b0, uop_num}, 32'(ptr));
          check("beat_lane_active", {28'b0, lane_active}, {28'b0, v.exp_la[(ptr%4)*4 +: 4]});
          check("beat_lane_en", {28'b0, lane_en}, {28'b0, v.exp_en[(ptr%4)*4 +: 4]});
          check("beat_last", {31'b0, uop_last}, {31'b0, (5'(ptr) == v.last_num)});
          ptr++;
          seen++;
        end
        @(negedge CLK);
        cyc++;
      end
    end
    check("done_seen", {31'b0, got_done}, 32'd1);
    check("beats_presented", 32'(seen), 32'($countones(v.present)));
    check("no_valid_in_done", {31'b0, uop_valid}, 32'd0);
    @(negedge CLK);
    check("done_one_cycle", {31'b0, done}, 32'd0);
    check("ready_after_done", {31'b0, issue_ready}, 32'd1);
  endtask

  task automatic run_long(input logic [7:0] vl, input bit toggle, input int exp_beats);
    int exp_num;
    int cyc;
    bit got_done;
    exp_num = 0; cyc = 0; got_done = 0;
    uop_ready = 1'b1;
    issue(vl, 1'b0, '0);
    while (!got_done && cyc < 200) begin
      if (done) got_done = 1;
      else begin
        if (uop_valid) begin
          check("long_num", {27'b0, uop_num}, 32'(exp_num));
          check("long_la", {28'b0, lane_active}, 32'hF);
          check("long_en", {28'b0, lane_en}, 32'hF);
          check("long_last", {31'b0, uop_last}, {31'b0, (exp_num == exp_beats - 1)});
        end
        uop_ready = toggle ? ~uop_ready : 1'b1;
        if (uop_valid && uop_ready) exp_num++;
        @(negedge CLK);
        cyc++;
      end
    end
    check("long_done_seen", {31'b0, got_done}, 32'd1);
    check("long_beats", 32'(exp_num), 32'(exp_beats));
    uop_ready = 1'b1;
    @(negedge CLK);
    check("long_done_pulse", {31'b0, done}, 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    nRST = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_vl = '0;
    issue_mask_en = 1'b0; issue_v0 = '0; uop_ready = 1'b1;

    vecs[0] = '{vl: 8'd8,  mask_en: 1'b0, v0: 16'h0000, present: 8'b0011, exp_la: 16'h00FF, exp_en: 16'h00FF, last_num: 5'd1};
    vecs[1] = '{vl: 8'd6,  mask_en: 1'b1, v0: 16'h00A6, present: 8'b0011, exp_la: 16'h003F, exp_en: 16'h0026, last_num: 5'd1};
`ifdef VSEQ_MASK_SKIP_EN
    vecs[2] = '{vl: 8'd16, mask_en: 1'b1, v0: 16'h0F00, present: 8'b0100, exp_la: 16'hFFFF, exp_en: 16'h0F00, last_num: 5'd3};
    vecs[6] = '{vl: 8'd9,  mask_en: 1'b1, v0: 16'h00F0, present: 8'b0010, exp_la: 16'h01FF, exp_en: 16'h00F0, last_num: 5'd2};
`else
    vecs[2] = '{vl: 8'd16, mask_en: 1'b1, v0: 16'h0F00, present: 8'b1111, exp_la: 16'hFFFF, exp_en: 16'h0F00, last_num: 5'd3};
    vecs[6] = '{vl: 8'd9,  mask_en: 1'b1, v0: 16'h00F0, present: 8'b0111, exp_la: 16'h01FF, exp_en: 16'h00F0, last_num: 5'd2};
`endif
    vecs[3] = '{vl: 8'd5,  mask_en: 1'b0, v0: 16'h0000, present: 8'b0011, exp_la: 16'h001F, exp_en: 16'h001F, last_num: 5'd1};
    vecs[4] = '{vl: 8'd1,  mask_en: 1'b1, v0: 16'h0001, present: 8'b0001, exp_la: 16'h0001, exp_en: 16'h0001, last_num: 5'd0};
    vecs[5] = '{vl: 8'd13, mask_en: 1'b1, v0: 16'h5A3C, present: 8'b1111, exp_la: 16'h1FFF, exp_en: 16'h1A3C, last_num: 5'd3};

    // reset values
    repeat (3) @(negedge CLK);
    check("rst_issue_ready", {31'b0, issue_ready}, 32'd1);
    check("rst_uop_valid", {31'b0, uop_valid}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_uop_num", {27'b0, uop_num}, 32'd0);
    check("rst_lane_active", {28'b0, lane_active}, 32'd0);
    check("rst_lane_en", {28'b0, lane_en}, 32'd0);
    check("rst_uop_last", {31'b0, uop_last}, 32'd0);
    nRST = 1'b1;

    for (int i = 0; i < 7; i++) run_case(vecs[i]);

    // full-length with stalls, and clamped over-length
    run_long(8'd128, 1'b1, 32);
    run_long(8'd200, 1'b0, 32);

    // zero-length instruction: no beats, one done pulse
    issue(8'd0, 1'b0, '0);
    check("vl0_no_valid", {31'b0, uop_valid}, 32'd0);
    check("vl0_done", {31'b0, done}, 32'd1);
    @(negedge CLK);
    check("vl0_done_once", {31'b0, done}, 32'd0);
    check("vl0_ready", {31'b0, issue_ready}, 32'd1);

    // flush on beat 2 of vl=16
    uop_ready = 1'b1;
    issue(8'd16, 1'b0, '0);
    @(negedge CLK);
    @(negedge CLK);
    check("flush_beat_num", {27'b0, uop_num}, 32'd2);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    check("flush_valid", {31'b0, uop_valid}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_ready", {31'b0, issue_ready}, 32'd1);
    @(negedge CLK);
    check("flush_no_late_done", {31'b0, done}, 32'd0);
    run_case('{vl: 8'd4, mask_en: 1'b0, v0: 16'h0000, present: 8'b0001, exp_la: 16'h000F, exp_en: 16'h000F, last_num: 5'd0});

    // flush together with issue drops the instruction
    @(negedge CLK);
    issue_valid = 1'b1; issue_vl = 8'd8; flush = 1'b1;
    @(negedge CLK);
    issue_valid = 1'b0; flush = 1'b0;
    check("drop_busy", {31'b0, busy}, 32'd0);
    check("drop_valid", {31'b0, uop_valid}, 32'd0);
    @(negedge CLK);
    check("drop_no_done", {31'b0, done}, 32'd0);

    // asynchronous reset in the middle of a run
    issue(8'd16, 1'b1, 128'hFFFF);
    @(negedge CLK);
    check("prerst_valid", {31'b0, uop_valid}, 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("arst_valid", {31'b0, uop_valid}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_ready", {31'b0, issue_ready}, 32'd1);
    check("arst_num", {27'b0, uop_num}, 32'd0);
    check("arst_la", {28'b0, lane_active}, 32'd0);
    check("arst_en", {28'b0, lane_en}, 32'd0);
    check("arst_last", {31'b0, uop_last}, 32'd0);
    check("arst_done", {31'b0, done}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check("postrst_done", {31'b0, done}, 32'd0);
    check("postrst_busy", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
